// File: rtl/done_collector.sv
// Purpose : collects per-lane instruction-completion reports and pulses insn_done_o once all lanes have reported an ID.
// Latency : 1 cycle from the final lane's grant to the insn_done_o pulse.
// Backpressure: one grant per lane per cycle (round-robin over that lane's VFUs); an ungranted lane holds valid/ID.
//
// Ports:
//   clk_i, rst_ni    clock (rising edge) and asynchronous active-low reset
//   lane_done_i      [lane][vfu] done valid
//   lane_done_id_i   [lane][vfu] instruction ID carried by each done
//   lane_done_gnt_o  [lane][vfu] done grant, combinational from valids and round-robin pointers
//   flush_i          synchronous clear of the report map, pulses and pointers
//   insn_done_o      [id] one-cycle completion pulse
//   dup_err_o        sticky flag: a lane re-reported an ID it still had recorded
module done_collector #(
  parameter int unsigned NrLanes   = 4,
  parameter int unsigned NrLaneVFU = 2,
  parameter int unsigned InsnIDNum = 8,
  localparam int unsigned IdW      = (InsnIDNum > 1) ? $clog2(InsnIDNum) : 1,
  localparam int unsigned RrW      = (NrLaneVFU > 1) ? $clog2(NrLaneVFU) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NrLanes-1:0][NrLaneVFU-1:0]           lane_done_i,
  input  logic [NrLanes-1:0][NrLaneVFU-1:0][IdW-1:0]  lane_done_id_i,
  output logic [NrLanes-1:0][NrLaneVFU-1:0]           lane_done_gnt_o,
  input  logic                                        flush_i,
  output logic [InsnIDNum-1:0]                        insn_done_o,
  output logic                                        dup_err_o
);

  // Wraps base+k into [0, NrLaneVFU) without a modulo operator.
  function automatic logic [RrW-1:0] rr_idx(input logic [RrW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= int'(NrLaneVFU)) sum = sum - int'(NrLaneVFU);
    return RrW'(sum);
  endfunction

  logic [NrLanes-1:0][RrW-1:0]          rr_q, rr_d;
  logic [NrLanes-1:0][NrLaneVFU-1:0]    gnt_raw;
  logic [NrLanes-1:0]                   lane_taken;

  logic [InsnIDNum-1:0][NrLanes-1:0]    map_q, map_d;
  logic [InsnIDNum-1:0][NrLanes-1:0]    new_bits;
  logic [InsnIDNum-1:0][NrLanes-1:0]    next_map;
  logic [InsnIDNum-1:0]                 complete;
  logic                                 dup_hit;

  // Per-lane round-robin: scan from rr[l] and grant the first valid VFU.
  // Only valids and the pointer feed this path; IDs never do.
  always_comb begin
    gnt_raw    = '0;
    lane_taken = '0;
    for (int l = 0; l < int'(NrLanes); l++) begin
      for (int k = 0; k < int'(NrLaneVFU); k++) begin
        if (!lane_taken[l] && lane_done_i[l][rr_idx(rr_q[l], k)]) begin
          gnt_raw[l][rr_idx(rr_q[l], k)] = 1'b1;
          lane_taken[l]                  = 1'b1;
        end
      end
    end
  end

  // No grants are offered while the block is held in reset.
  assign lane_done_gnt_o = rst_ni ? gnt_raw : '0;

  // Pointer moves just past the granted VFU; a flush restarts every lane at VFU 0.
  always_comb begin
    rr_d = rr_q;
    for (int l = 0; l < int'(NrLanes); l++) begin
      for (int v = 0; v < int'(NrLaneVFU); v++) begin
        if (lane_done_gnt_o[l][v]) begin
          rr_d[l] = (v == int'(NrLaneVFU) - 1) ? '0 : RrW'(v + 1);
        end
      end
    end
    if (flush_i) rr_d = '0;
  end

  // Bits contributed by this cycle's grants, and detection of a lane
  // reporting an ID whose bit it already holds.
  always_comb begin
    new_bits = '0;
    dup_hit  = 1'b0;
    for (int l = 0; l < int'(NrLanes); l++) begin
      for (int v = 0; v < int'(NrLaneVFU); v++) begin
        if (lane_done_gnt_o[l][v]) begin
          new_bits[lane_done_id_i[l][v]][l] = 1'b1;
          if (map_q[lane_done_id_i[l][v]][l]) dup_hit = 1'b1;
        end
      end
    end
  end

  assign next_map = map_q | new_bits;

  // Completion is judged on the merged map so the last lane's grant counts in
  // the same cycle; a completed row is cleared rather than keeping that grant.
  always_comb begin
    complete = '0;
    map_d    = '0;
    for (int id = 0; id < int'(InsnIDNum); id++) begin
      complete[id] = &next_map[id];
      map_d[id]    = complete[id] ? '0 : next_map[id];
    end
    if (flush_i) map_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      map_q       <= '0;
      insn_done_o <= '0;
      dup_err_o   <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      map_q       <= map_d;
      insn_done_o <= flush_i ? '0 : complete;
      // Grants taken during a flush are discarded, so they cannot flag a duplicate.
      dup_err_o   <= dup_err_o | (dup_hit & ~flush_i);
    end
  end

endmodule

// File: tb/tb_done_collector.sv
module tb_done_collector;
  localparam int NL = 4;
  localparam int NV = 2;
  localparam int NI = 8;
  localparam int IW = 3;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic [NL-1:0][NV-1:0]           vld;
  logic [NL-1:0][NV-1:0][IW-1:0]   ids;
  logic                            flush;
  logic [NL-1:0][NV-1:0]           gnt;
  logic [NI-1:0]                   done;
  logic                            dup;

  always #5 clk = ~clk;

  done_collector #(.NrLanes(NL), .NrLaneVFU(NV), .InsnIDNum(NI)) dut (
    .clk_i(clk), .rst_ni(rst_n), .lane_done_i(vld), .lane_done_id_i(ids),
    .lane_done_gnt_o(gnt), .flush_i(flush), .insn_done_o(done), .dup_err_o(dup)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which lanes have reported each ID, a round-robin
  // pointer per lane as a plain integer, and a sticky duplicate flag.
  bit                    m_rep[NI][NL];
  int                    m_rr[NL];
  bit                    m_dup;
  logic [NL-1:0][NV-1:0] e_gnt;
  logic [NI-1:0]         e_done;
  logic                  e_dup;

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) for (int l = 0; l < NL; l++) m_rep[i][l] = 1'b0;
    for (int l = 0; l < NL; l++) m_rr[l] = 0;
    m_dup = 1'b0; e_gnt = '0; e_done = '0; e_dup = 1'b0;
  endfunction

  function automatic void model_grant();
    int  v;
    bit  found;
    e_gnt = '0;
    if (!rst_n) return;
    for (int l = 0; l < NL; l++) begin
      found = 1'b0;
      for (int k = 0; k < NV; k++) begin
        v = (m_rr[l] + k) % NV;
        if (!found && vld[l][v]) begin
          e_gnt[l][v] = 1'b1;
          found = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_commit();
    int id;
    int cnt;
    e_done = '0;
    if (flush) begin
      for (int i = 0; i < NI; i++) for (int l = 0; l < NL; l++) m_rep[i][l] = 1'b0;
      for (int l = 0; l < NL; l++) m_rr[l] = 0;
      e_dup = m_dup;
      return;
    end
    for (int l = 0; l < NL; l++) begin
      for (int v = 0; v < NV; v++) begin
        if (e_gnt[l][v]) begin
          id = int'(ids[l][v]);
          if (m_rep[id][l]) m_dup = 1'b1;
          m_rep[id][l] = 1'b1;
          m_rr[l] = (v + 1) % NV;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      cnt = 0;
      for (int l = 0; l < NL; l++) cnt += int'(m_rep[i][l]);
      if (cnt == NL) begin
        e_done[i] = 1'b1;
        for (int l = 0; l < NL; l++) m_rep[i][l] = 1'b0;
      end
    end
    e_dup = m_dup;
  endfunction

  task automatic clear_req();
    vld = '0; ids = '0; flush = 1'b0;
  endtask

  // Inputs are driven at the falling edge; grants are sampled 1 time unit later.
  task automatic settle();
    #1;
    model_grant();
  endtask

  // Model advances on the rising edge; registered outputs are sampled 1 unit after.
  task automatic clock_edge();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_req();
    model_reset();
    repeat (2) @(negedge clk);
    vld = '1;
    #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %h want 00", gnt); end
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done got %h want 00", done); end
    checks++; if (dup !== 1'b0) begin errors++; $display("FAIL reset_dup got %b want 0", dup); end
    @(negedge clk);
    clear_req();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_all_lanes();
    logic [NL-1:0][NV-1:0] want_g;
    logic [NI-1:0]         want_d;
    want_g = 8'h55;
    want_d = 8'h08;
    clear_req();
    for (int l = 0; l < NL; l++) begin vld[l][0] = 1'b1; ids[l][0] = 3'd3; end
    settle();
    checks++; if (gnt !== want_g) begin errors++; $display("FAIL all_lanes_gnt got %h want %h", gnt, want_g); end
    clock_edge();
    checks++; if (done !== want_d) begin errors++; $display("FAIL all_lanes_done got %h want %h", done, want_d); end
    @(negedge clk);
    clear_req();
    settle();
    clock_edge();
    checks++; if (done !== '0) begin errors++; $display("FAIL all_lanes_pulse_width got %h want 00", done); end
    @(negedge clk);
  endtask

  task automatic test_staggered();
    logic [NI-1:0] want_d;
    for (int c = 1; c <= 10; c++) begin
      clear_req();
      if (c <= 3) begin vld[c-1][0] = 1'b1; ids[c-1][0] = 3'd5; end
      if (c == 7 || c == 10) begin vld[3][0] = 1'b1; ids[3][0] = 3'd5; end
      if (c == 9) for (int l = 0; l < 3; l++) begin vld[l][0] = 1'b1; ids[l][0] = 3'd5; end
      settle();
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL staggered_gnt c=%0d got %h want %h", c, gnt, e_gnt); end
      clock_edge();
      want_d = (c == 7 || c == 10) ? 8'h20 : 8'h00;
      checks++; if (done !== want_d) begin errors++; $display("FAIL staggered_done c=%0d got %h want %h", c, done, want_d); end
      checks++; if (dup !== e_dup) begin errors++; $display("FAIL staggered_dup c=%0d got %b want %b", c, dup, e_dup); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    logic [NI-1:0] want_d;
    for (int c = 0; c < 6; c++) begin
      clear_req();
      case (c)
        0: for (int l = 0; l < 3; l++) begin vld[l][0] = 1'b1; ids[l][0] = 3'd6; end
        1: begin flush = 1'b1; vld[0][1] = 1'b1; ids[0][1] = 3'd6; end
        2: begin vld[3][0] = 1'b1; ids[3][0] = 3'd6; end
        3: for (int l = 1; l < 3; l++) begin vld[l][0] = 1'b1; ids[l][0] = 3'd6; end
        4: begin vld[0][0] = 1'b1; ids[0][0] = 3'd6; end
        default: ;
      endcase
      settle();
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL flush_gnt c=%0d got %h want %h", c, gnt, e_gnt); end
      clock_edge();
      want_d = (c == 4) ? 8'h40 : 8'h00;
      checks++; if (done !== want_d) begin errors++; $display("FAIL flush_done c=%0d got %h want %h", c, done, want_d); end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_alternate();
    logic [NV-1:0] want0;
    clear_req();
    flush = 1'b1;
    settle();
    clock_edge();
    @(negedge clk);
    clear_req();
    vld[0] = 2'b11; ids[0][0] = 3'd1; ids[0][1] = 3'd2;
    for (int k = 0; k < 4; k++) begin
      settle();
      want0 = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (gnt[0] !== want0) begin errors++; $display("FAIL rr_lane0 k=%0d got %b want %b", k, gnt[0], want0); end
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rr_gnt k=%0d got %h want %h", k, gnt, e_gnt); end
      clock_edge();
      checks++; if (dup !== e_dup) begin errors++; $display("FAIL rr_dup k=%0d got %b want %b", k, dup, e_dup); end
      @(negedge clk);
    end
    clear_req();
  endtask

  task automatic test_reset_mid();
    clear_req();
    for (int l = 0; l < 3; l++) begin vld[l][0] = 1'b1; ids[l][0] = 3'd7; end
    settle();
    clock_edge();
    @(negedge clk);
    clear_req();
    vld[3][0] = 1'b1; ids[3][0] = 3'd7;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL midreset_gnt got %h want 00", gnt); end
    checks++; if (dup !== 1'b0) begin errors++; $display("FAIL midreset_dup got %b want 0", dup); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      if (c == 1) clear_req();
      settle();
      clock_edge();
      checks++; if (done !== '0) begin errors++; $display("FAIL midreset_done c=%0d got %h want 00", c, done); end
      @(negedge clk);
    end
  endtask

  task automatic test_dup();
    logic [NI-1:0] want_d;
    logic          want_dup;
    for (int c = 0; c < 4; c++) begin
      clear_req();
      if (c < 2) begin vld[2][0] = 1'b1; ids[2][0] = 3'd4; end
      if (c == 2) for (int l = 0; l < NL; l++) if (l != 2) begin vld[l][0] = 1'b1; ids[l][0] = 3'd4; end
      settle();
      clock_edge();
      want_dup = (c >= 1);
      want_d   = (c == 2) ? 8'h10 : 8'h00;
      checks++; if (dup !== want_dup) begin errors++; $display("FAIL dup_flag c=%0d got %b want %b", c, dup, want_dup); end
      checks++; if (done !== want_d) begin errors++; $display("FAIL dup_done c=%0d got %h want %h", c, done, want_d); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    clear_req();
    e_gnt = '0;
    for (int n = 0; n < 400; n++) begin
      // Granted requests leave; idle slots may raise a new one. Held requests keep their ID.
      for (int l = 0; l < NL; l++) begin
        for (int v = 0; v < NV; v++) begin
          if (e_gnt[l][v]) vld[l][v] = 1'b0;
          if (!vld[l][v] && $urandom_range(0, 1) == 1) begin
            vld[l][v] = 1'b1;
            ids[l][v] = IW'($urandom_range(0, NI - 1));
          end
        end
      end
      flush = ($urandom_range(0, 29) == 0);
      settle();
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL random_gnt n=%0d got %h want %h", n, gnt, e_gnt); end
      clock_edge();
      checks++; if (done !== e_done) begin errors++; $display("FAIL random_done n=%0d got %h want %h", n, done, e_done); end
      checks++; if (dup !== e_dup) begin errors++; $display("FAIL random_dup n=%0d got %b want %b", n, dup, e_dup); end
      @(negedge clk);
    end
    clear_req();
  endtask

  initial begin
    test_reset();
    test_all_lanes();
    test_staggered();
    test_flush();
    test_rr_alternate();
    test_reset_mid();
    test_dup();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/done_collector.md
DONE_COLLECTOR -- requirements
Module: done_collector

Interface
REQ-001 SHALL have parameter NrLanes, default 4: number of lanes reporting completions.
REQ-002 SHALL have parameter NrLaneVFU, default 2: number of done-reporting VFUs per lane.
REQ-003 SHALL have parameter InsnIDNum, default 8: number of instruction IDs; IdW = clog2(InsnIDNum).
REQ-004 SHALL use one clock, clk_i, and an asynchronous active-low reset, rst_ni.
REQ-005 clk_i  input  1  clock; all state on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 lane_done_i  input  NrLanes x NrLaneVFU  per-lane, per-VFU done valid.
REQ-008 lane_done_id_i  input  NrLanes x NrLaneVFU x IdW  instruction ID of each done.
REQ-009 lane_done_gnt_o  output  NrLanes x NrLaneVFU  per-lane, per-VFU done grant.
REQ-010 flush_i  input  1  synchronous clear of all tracking state.
REQ-011 insn_done_o  output  InsnIDNum  one-cycle pulse per ID, set when every lane has reported that ID.
REQ-012 dup_err_o  output  1  sticky flag: a lane reported an ID it had already reported.

Function
REQ-013 Handshake SHALL be valid/grant: a done transfers in a cycle where both lane_done_i[l][v] and lane_done_gnt_o[l][v] are high; the lane holds valid and ID stable until granted.
REQ-014 lane_done_gnt_o SHALL be combinational from lane_done_i and the per-lane round-robin pointer, with no combinational dependence on lane_done_id_i.
REQ-015 Per lane, at most one VFU SHALL be granted per cycle.
REQ-016 Grant SHALL be one-hot among the lane's valid VFUs, chosen round-robin starting at pointer rr[l].
REQ-017 On a grant to VFU v in lane l, rr[l] SHALL become (v+1) mod NrLaneVFU at the next edge; with no grant, rr[l] holds.
REQ-018 Lanes SHALL be arbitrated independently; all lanes may be granted in the same cycle.
REQ-019 The block SHALL keep a report map map[id][lane], one bit per ID per lane.
REQ-020 Each granted transfer SHALL set map[lane_done_id][l] at the next edge.
REQ-021 Completion SHALL be evaluated on next_map = map | new_bits (this cycle's grants).
REQ-022 If next_map[id] is all ones, then at the next edge: insn_done_o[id] rises for exactly one cycle, and map[id] clears to 0.
REQ-023 Latency SHALL be 1 cycle from the final lane's grant to the insn_done_o pulse.
REQ-024 Multiple IDs completing in the same cycle SHALL all pulse together.
REQ-025 If map[id][l] is already 1 when lane l is granted for id, dup_err_o SHALL set at the next edge and remain set until reset; the map bit stays 1.
REQ-026 A grant to an ID completing in the same cycle SHALL count toward that completion and SHALL NOT be retained after the clear.
REQ-027 Different lanes reporting the same ID in the same cycle SHALL all be recorded.
REQ-028 With NrLanes=1, each grant SHALL complete its ID immediately; the map never retains bits.
REQ-029 flush_i=1 SHALL, at the next edge: clear the map, clear insn_done_o, and reset all rr to 0; grants in that cycle are accepted but discarded; dup_err_o is unaffected.

Reset
REQ-030 While rst_ni=0: map=0, rr=0, insn_done_o=0, dup_err_o=0.
REQ-031 While rst_ni=0, lane_done_gnt_o SHALL be 0.
REQ-032 Reset asserted mid-accumulation SHALL discard partial maps; no insn_done_o pulse follows reset release.

Verification
REQ-033 All 4 lanes assert VALU done id=3 in the same cycle -> insn_done_o=8'h08 pulses one cycle later, for one cycle.
REQ-034 Lanes 0,1,2 report id=5 in cycles 1,2,3 and lane 3 in cycle 7 -> insn_done_o[5] pulses only in cycle 8; map[5]=0 afterwards.
REQ-035 Lane 0 holds both VFUs valid (VFU0 id=1, VFU1 id=2) for 4 cycles -> grants alternate VFU0, VFU1, VFU0, VFU1; never both granted in one cycle.
REQ-036 Lane 2 reports id=4 twice before the other lanes report -> dup_err_o=1 from the next cycle and stays 1; id=4 still completes once the other three lanes report.
REQ-037 Three lanes report id=6, then flush_i pulses, then lane 3 reports id=6 -> no insn_done_o pulse.
REQ-038 Reset asserted with a partial map -> no insn_done_o pulse after reset release.
